// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and widths for the core memory-port arbiter.
// Optional WAIT watchdog is enabled by defining ARB_TIMEOUT_EN.
package mem_port_arbiter_pkg;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    localparam int MASK_W = DATA_W / 8;
    localparam int INSN_W = 32;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_WAIT = 2'd2,
        ARB_RESP = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWNER_IF  = 1'b0,
        OWNER_MEM = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_port_arbiter_arb_grant.sv
// MEM-first grant with an IF anti-starvation counter.
// Grants are only raised while the arbiter is idle.
module arb_grant #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic idle,
    input  logic if_req_valid,
    input  logic mem_req_valid,
    output logic grant_if,
    output logic grant_mem
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] starve_cnt;
    logic          starved;

    assign starved   = if_req_valid && (starve_cnt == CW'(STARVE_LIMIT));
    assign grant_mem = idle && mem_req_valid && !starved;
    assign grant_if  = idle && if_req_valid && !grant_mem;

    // A grant is a handshake: grants imply valid and idle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (grant_mem && if_req_valid) begin
            if (starve_cnt != CW'(STARVE_LIMIT))
                starve_cnt <= starve_cnt + CW'(1);
        end else if (grant_if || grant_mem) begin
            starve_cnt <= '0;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises IF and MEM requests onto one memory port.
// Define ARB_TIMEOUT_EN to add the WAIT-state watchdog.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_rsp_valid,
    output logic [INSN_W-1:0] if_rsp_data,
    input  logic              mem_req_valid,
    output logic              mem_req_ready,
    input  logic              mem_req_wr,
    input  logic [ADDR_W-1:0] mem_req_addr,
    input  logic [DATA_W-1:0] mem_req_wdata,
    input  logic [MASK_W-1:0] mem_req_wmask,
    output logic              mem_rsp_valid,
    output logic [DATA_W-1:0] mem_rsp_data,
    output logic              bus_req_valid,
    input  logic              bus_req_ready,
    output logic              bus_wr,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [MASK_W-1:0] bus_wmask,
    input  logic              bus_rsp_valid,
    input  logic [DATA_W-1:0] bus_rsp_data,
    output logic              arb_timeout
);

    arb_state_e        state;
    owner_e            owner;
    logic              addr2;
    logic              idle;
    logic              grant_if;
    logic              grant_mem;
    logic              timed_out;
    logic [DATA_W-1:0] rsp_dw;
    logic [INSN_W-1:0] rsp_word;

    assign idle          = (state == ARB_IDLE) && reset;
    assign if_req_ready  = grant_if;
    assign mem_req_ready = grant_mem;

    // A timeout returns zero data unless the response lands that cycle.
    assign rsp_dw   = bus_rsp_valid ? bus_rsp_data : '0;
    assign rsp_word = addr2 ? rsp_dw[63:32] : rsp_dw[31:0];

    arb_grant #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_grant (
        .clock         (clock),
        .reset         (reset),
        .idle          (idle),
        .if_req_valid  (if_req_valid),
        .mem_req_valid (mem_req_valid),
        .grant_if      (grant_if),
        .grant_mem     (grant_mem)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= ARB_IDLE;
            owner         <= OWNER_IF;
            addr2         <= 1'b0;
            bus_req_valid <= 1'b0;
            bus_wr        <= 1'b0;
            bus_addr      <= '0;
            bus_wdata     <= '0;
            bus_wmask     <= '0;
            if_rsp_valid  <= 1'b0;
            if_rsp_data   <= '0;
            mem_rsp_valid <= 1'b0;
            mem_rsp_data  <= '0;
        end else begin
            unique case (state)
                ARB_IDLE: begin
                    if (grant_mem || grant_if) begin
                        state         <= ARB_REQ;
                        bus_req_valid <= 1'b1;
                        owner         <= grant_mem ? OWNER_MEM : OWNER_IF;
                        addr2         <= if_addr[2];
                        bus_wr        <= grant_mem && mem_req_wr;
                        bus_addr      <= grant_mem ? mem_req_addr : if_addr;
                        bus_wdata     <= grant_mem ? mem_req_wdata : '0;
                        bus_wmask     <= (grant_mem && mem_req_wr) ?
                                         mem_req_wmask : '0;
                    end
                end
                ARB_REQ: begin
                    if (bus_req_ready) begin
                        state         <= ARB_WAIT;
                        bus_req_valid <= 1'b0;
                    end
                end
                ARB_WAIT: begin
                    if (bus_rsp_valid || timed_out) begin
                        state         <= ARB_RESP;
                        if_rsp_valid  <= (owner == OWNER_IF);
                        mem_rsp_valid <= (owner == OWNER_MEM);
                        if_rsp_data   <= rsp_word;
                        mem_rsp_data  <= rsp_dw;
                    end
                end
                ARB_RESP: begin
                    state         <= ARB_IDLE;
                    if_rsp_valid  <= 1'b0;
                    mem_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CLOG_T = $clog2(TIMEOUT_CYCLES + 1);
    localparam int TW     = (CLOG_T > 8) ? CLOG_T : 8;

    logic [TW-1:0] wait_cnt;
    logic          timeout_q;

    assign timed_out   = (state == ARB_WAIT) &&
                         (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign arb_timeout = timeout_q;

    // Counter idles at zero, so it restarts on every WAIT entry.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timed_out && !bus_rsp_valid;
            if (state == ARB_WAIT)
                wait_cnt <= wait_cnt + TW'(1);
            else
                wait_cnt <= '0;
        end
    end
`else
    logic [31:0] unused_timeout;

    assign unused_timeout = TIMEOUT_CYCLES;
    assign timed_out      = 1'b0;
    assign arb_timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter.
// Covers ARB_TIMEOUT_EN behaviour when that macro is defined.
module tb_mem_port_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        if_req_valid = 1'b0;
    logic        if_req_ready;
    logic [63:0] if_addr = '0;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_data;
    logic        mem_req_valid = 1'b0;
    logic        mem_req_ready;
    logic        mem_req_wr = 1'b0;
    logic [63:0] mem_req_addr = '0;
    logic [63:0] mem_req_wdata = '0;
    logic [7:0]  mem_req_wmask = '0;
    logic        mem_rsp_valid;
    logic [63:0] mem_rsp_data;
    logic        bus_req_valid;
    logic        bus_req_ready = 1'b0;
    logic        bus_wr;
    logic [63:0] bus_addr;
    logic [63:0] bus_wdata;
    logic [7:0]  bus_wmask;
    logic        bus_rsp_valid = 1'b0;
    logic [63:0] bus_rsp_data = '0;
    logic        arb_timeout;

    int vectors     = 0;
    int miscompares = 0;
    int if_pulses   = 0;
    int mem_pulses  = 0;
    int p0;

    mem_port_arbiter #(
        .STARVE_LIMIT   (4),
        .TIMEOUT_CYCLES (10)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .if_req_valid  (if_req_valid),
        .if_req_ready  (if_req_ready),
        .if_addr       (if_addr),
        .if_rsp_valid  (if_rsp_valid),
        .if_rsp_data   (if_rsp_data),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_wr    (mem_req_wr),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wdata (mem_req_wdata),
        .mem_req_wmask (mem_req_wmask),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .bus_req_valid (bus_req_valid),
        .bus_req_ready (bus_req_ready),
        .bus_wr        (bus_wr),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_wmask     (bus_wmask),
        .bus_rsp_valid (bus_rsp_valid),
        .bus_rsp_data  (bus_rsp_data),
        .arb_timeout   (arb_timeout)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (if_rsp_valid)  if_pulses++;
        if (mem_rsp_valid) mem_pulses++;
    end

    // Ungranted requests must keep valid and payload stable.
    logic        p_rst, p_if_v, p_if_r, p_mem_v, p_mem_r, p_wr;
    logic [63:0] p_if_a, p_mem_a, p_wd;
    logic [7:0]  p_wm;
    always @(posedge clock) begin
        if (reset && p_rst) begin
            if (p_if_v && !p_if_r)
                assert (if_req_valid && if_addr == p_if_a)
                    else $error("if request changed before grant");
            if (p_mem_v && !p_mem_r)
                assert (mem_req_valid && mem_req_addr == p_mem_a &&
                        mem_req_wr == p_wr && mem_req_wdata == p_wd &&
                        mem_req_wmask == p_wm)
                    else $error("mem request changed before grant");
        end
        p_rst   = reset;
        p_if_v  = if_req_valid;
        p_if_r  = if_req_ready;
        p_if_a  = if_addr;
        p_mem_v = mem_req_valid;
        p_mem_r = mem_req_ready;
        p_mem_a = mem_req_addr;
        p_wr    = mem_req_wr;
        p_wd    = mem_req_wdata;
        p_wm    = mem_req_wmask;
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic smp();
        @(negedge clock);
    endtask

    function automatic logic outs_nonzero();
        return |{if_req_ready, if_rsp_valid, if_rsp_data, mem_req_ready,
                 mem_rsp_valid, mem_rsp_data, bus_req_valid, bus_wr,
                 bus_addr, bus_wdata, bus_wmask, arb_timeout};
    endfunction

    task automatic do_reset();
        if_req_valid  = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_wr    = 1'b0;
        bus_req_ready = 1'b0;
        bus_rsp_valid = 1'b0;
        reset = 1'b0;
        cyc();
        cyc();
        reset = 1'b1;
    endtask

    // Called in REQ: accept now, answer in WAIT, return in RESP.
    task automatic bus_tail(input logic [63:0] d);
        bus_req_ready = 1'b1;
        cyc();
        bus_req_ready = 1'b0;
        bus_rsp_valid = 1'b1;
        bus_rsp_data  = d;
        cyc();
        bus_rsp_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset state and IF-only read with 3-cycle latency
        do_reset();
        smp();
        check("rst_outs_zero", outs_nonzero(), 1'b0);
        cyc();
        if_req_valid  = 1'b1;
        if_addr       = 64'h8000_0004;
        bus_req_ready = 1'b1;
        smp();
        check("t1_if_ready", if_req_ready, 1'b1);
        check("t1_mem_ready", mem_req_ready, 1'b0);
        cyc();
        if_req_valid = 1'b0;
        smp();
        check("t1_req_valid", bus_req_valid, 1'b1);
        check("t1_bus_addr", bus_addr, 64'h8000_0004);
        check("t1_bus_wmask", bus_wmask, 8'h00);
        cyc();
        bus_req_ready = 1'b0;
        bus_rsp_valid = 1'b1;
        bus_rsp_data  = 64'h1111_2222_3333_4444;
        smp();
        check("t1_wait_req", bus_req_valid, 1'b0);
        check("t1_wait_rsp", if_rsp_valid, 1'b0);
        cyc();
        bus_rsp_valid = 1'b0;
        smp();
        check("t1_rsp_valid", if_rsp_valid, 1'b1);
        check("t1_rsp_data", if_rsp_data, 32'h1111_2222);
        check("t1_mem_rsp", mem_rsp_valid, 1'b0);
        cyc();
        smp();
        check("t1_rsp_once", if_rsp_valid, 1'b0);

        // Simultaneous IF and MEM load: MEM first
        do_reset();
        if_req_valid  = 1'b1;
        if_addr       = 64'h8000_0008;
        mem_req_valid = 1'b1;
        mem_req_addr  = 64'h8000_2000;
        smp();
        check("t2_mem_ready", mem_req_ready, 1'b1);
        check("t2_if_ready0", if_req_ready, 1'b0);
        cyc();
        mem_req_valid = 1'b0;
        bus_req_ready = 1'b1;
        smp();
        check("t2_bus_addr", bus_addr, 64'h8000_2000);
        check("t2_bus_wr", bus_wr, 1'b0);
        check("t2_if_ready1", if_req_ready, 1'b0);
        cyc();
        bus_req_ready = 1'b0;
        bus_rsp_valid = 1'b1;
        bus_rsp_data  = 64'h0123_4567_89ab_cdef;
        smp();
        check("t2_if_ready2", if_req_ready, 1'b0);
        cyc();
        bus_rsp_valid = 1'b0;
        smp();
        check("t2_mem_rsp", mem_rsp_valid, 1'b1);
        check("t2_mem_data", mem_rsp_data, 64'h0123_4567_89ab_cdef);
        check("t2_if_ready3", if_req_ready, 1'b0);
        cyc();
        smp();
        check("t2_if_granted", if_req_ready, 1'b1);
        cyc();
        if_req_valid = 1'b0;
        smp();
        check("t2_if_addr", bus_addr, 64'h8000_0008);
        bus_tail(64'hcafe_f00d_5555_aaaa);
        smp();
        check("t2_if_rsp", if_rsp_valid, 1'b1);
        check("t2_if_low", if_rsp_data, 32'h5555_aaaa);
        cyc();

        // Starvation: grants M M M M I M
        do_reset();
        if_req_valid  = 1'b1;
        if_addr       = 64'h8000_0010;
        mem_req_valid = 1'b1;
        mem_req_addr  = 64'h8000_3000;
        for (int k = 0; k < 6; k++) begin
            smp();
            check($sformatf("t3_grant%0d", k),
                  {if_req_ready, mem_req_ready},
                  (k == 4) ? 2'b10 : 2'b01);
            cyc();
            bus_tail(64'(k));
            smp();
            cyc();
        end

        // Store with bus accept delayed 3 cycles
        do_reset();
        mem_req_valid = 1'b1;
        mem_req_wr    = 1'b1;
        mem_req_addr  = 64'h8000_1000;
        mem_req_wdata = 64'h0000_0000_dead_beef;
        mem_req_wmask = 8'h0f;
        smp();
        check("t4_mem_ready", mem_req_ready, 1'b1);
        cyc();
        mem_req_valid = 1'b0;
        mem_req_wr    = 1'b0;
        mem_req_addr  = '0;
        mem_req_wdata = '0;
        mem_req_wmask = '0;
        bus_rsp_valid = 1'b1;
        p0 = mem_pulses;
        for (int k = 0; k < 3; k++) begin
            smp();
            check($sformatf("t4_valid%0d", k), bus_req_valid, 1'b1);
            check($sformatf("t4_wr%0d", k), bus_wr, 1'b1);
            check($sformatf("t4_addr%0d", k), bus_addr, 64'h8000_1000);
            check($sformatf("t4_wdata%0d", k), bus_wdata,
                  64'h0000_0000_dead_beef);
            check($sformatf("t4_wmask%0d", k), bus_wmask, 8'h0f);
            cyc();
        end
        bus_rsp_valid = 1'b0;
        smp();
        check("t4_still_req", bus_req_valid, 1'b1);
        bus_req_ready = 1'b1;
        cyc();
        bus_req_ready = 1'b0;
        bus_rsp_valid = 1'b1;
        bus_rsp_data  = '0;
        cyc();
        bus_rsp_valid = 1'b0;
        smp();
        check("t4_ack", mem_rsp_valid, 1'b1);
        repeat (3) cyc();
        check("t4_one_pulse", 64'(mem_pulses - p0), 64'd1);

        // Reset during WAIT drops the transaction
        do_reset();
        mem_req_valid = 1'b1;
        mem_req_addr  = 64'h8000_4000;
        cyc();
        mem_req_valid = 1'b0;
        bus_req_ready = 1'b1;
        cyc();
        bus_req_ready = 1'b0;
        smp();
        reset = 1'b0;
        #1;
        check("t5_in_reset", outs_nonzero(), 1'b0);
        cyc();
        reset = 1'b1;
        p0 = if_pulses + mem_pulses;
        bus_rsp_valid = 1'b1;
        bus_rsp_data  = 64'hffff_ffff_ffff_ffff;
        repeat (3) cyc();
        bus_rsp_valid = 1'b0;
        smp();
        check("t5_no_pulse", 64'(if_pulses + mem_pulses - p0), 64'd0);
        check("t5_outs_zero", outs_nonzero(), 1'b0);
        cyc();
        if_req_valid = 1'b1;
        if_addr      = 64'h8000_0020;
        smp();
        check("t5_idle", if_req_ready, 1'b1);
        cyc();
        if_req_valid = 1'b0;
        bus_tail(64'h0);
        cyc();

`ifdef ARB_TIMEOUT_EN
        // Watchdog fires after 10 WAIT cycles with zero data
        do_reset();
        mem_req_valid = 1'b1;
        mem_req_addr  = 64'h8000_5000;
        bus_rsp_data  = 64'hbad0_bad0_bad0_bad0;
        cyc();
        mem_req_valid = 1'b0;
        bus_req_ready = 1'b1;
        cyc();
        bus_req_ready = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            smp();
            check($sformatf("t6_wait%0d", k),
                  {arb_timeout, mem_rsp_valid}, 2'b00);
            cyc();
        end
        smp();
        check("t6_timeout", arb_timeout, 1'b1);
        check("t6_rsp", mem_rsp_valid, 1'b1);
        check("t6_data", mem_rsp_data, 64'h0);
        cyc();
        bus_rsp_valid = 1'b1;
        p0 = mem_pulses;
        smp();
        check("t6_pulse_end", {arb_timeout, mem_rsp_valid}, 2'b00);
        cyc();
        cyc();
        bus_rsp_valid = 1'b0;
        check("t6_late_ignored", 64'(mem_pulses - p0), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single core memory port between two requesters: instruction fetch (IF, read-only) and the MEM stage (load/store).
- Sits between the IF/MEM stages and the external memory interface.
- Serialises one transaction at a time through a 4-state FSM.
- Uses MEM-first priority with an IF anti-starvation limit.

Parameters:
- STARVE_LIMIT, 4: consecutive MEM grants allowed while IF is waiting before IF is forced.
- TIMEOUT_CYCLES, 255: WAIT-state watchdog limit; used only with ARB_TIMEOUT_EN.

Ports:
- clock  in  1  core clock
- reset  in  1  asynchronous, active-low reset
- if_req_valid  in  1  fetch request
- if_req_ready  out  1  fetch request accepted this cycle
- if_addr  in  64  fetch address, 4-byte aligned
- if_rsp_valid  out  1  one-cycle fetch response pulse
- if_rsp_data  out  32  fetched instruction
- mem_req_valid  in  1  data request
- mem_req_ready  out  1  data request accepted this cycle
- mem_req_wr  in  1  1 = store, 0 = load
- mem_req_addr  in  64  data address
- mem_req_wdata  in  64  store data
- mem_req_wmask  in  8  store byte mask
- mem_rsp_valid  out  1  one-cycle data response pulse (load data or store ack)
- mem_rsp_data  out  64  load data
- bus_req_valid  out  1  request to memory
- bus_req_ready  in  1  memory accepts request
- bus_wr  out  1  write enable
- bus_addr  out  64  address
- bus_wdata  out  64  write data
- bus_wmask  out  8  byte mask (8'h00 for reads)
- bus_rsp_valid  in  1  memory response
- bus_rsp_data  in  64  memory read data
- arb_timeout  out  1  watchdog error pulse

Behaviour:
- Reset (reset low, asynchronous):
  - FSM goes to IDLE; starvation counter = 0.
  - Every output = 0, including all bus_* and rsp data.
  - Any in-flight transaction is dropped; no response is issued after reset releases.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE, grant (combinational):
  - If mem_req_valid and not (if_req_valid and starve_cnt == STARVE_LIMIT): grant MEM.
  - Else if if_req_valid: grant IF.
  - Only the granted requester sees its req_ready = 1; both ready = 0 outside IDLE.
- IDLE, on handshake:
  - Latch owner, wr, addr, wdata, wmask (wmask forced to 0 and wr to 0 for IF).
  - Latch IF addr[2]; go to REQ.
- Starvation counter:
  - Increments on a MEM grant while if_req_valid = 1; saturates at STARVE_LIMIT.
  - Clears on an IF grant, or on a MEM grant with if_req_valid = 0.
- REQ:
  - bus_req_valid = 1; bus_* hold the latched values, stable until accepted.
  - On bus_req_ready go to WAIT.
- WAIT:
  - bus_req_valid = 0; bus_rsp_valid is ignored in REQ and honoured only here.
  - On bus_rsp_valid, latch bus_rsp_data and go to RESP.
- RESP:
  - Exactly one cycle of if_rsp_valid or mem_rsp_valid for the owner, then IDLE.
  - if_rsp_data = latched addr[2] ? data[63:32] : data[31:0].
  - mem_rsp_data = the full 64 bits.
  - Store transactions still pulse mem_rsp_valid (acknowledge).
- Responses carry no backpressure; requesters must accept the pulse.
- Latency:
  - Request accepted in cycle N; bus_req_valid from N+1.
  - Best case: bus accept at N+1, response at N+2, client rsp_valid at N+3.
  - Back-to-back: the next grant is possible in the cycle after RESP.
- Simultaneous requests at reset release: MEM wins.
- Requests that are not granted must hold valid and payload stable (checked by assertion in the bench).
- Addresses are 64-bit with no wrap handling; misaligned IF addresses are used unchanged except for bit 2.

Optional Feature:
- ARB_TIMEOUT_EN defined:
  - An 8-bit-minimum WAIT counter resets on WAIT entry.
  - If it reaches TIMEOUT_CYCLES without bus_rsp_valid: go to RESP with data 0 and pulse arb_timeout for one cycle, aligned with the owner's rsp_valid.
  - A late bus_rsp_valid after the timeout is ignored.
- ARB_TIMEOUT_EN undefined: no counter; WAIT persists indefinitely; arb_timeout is tied to 0.

Decomposition:
- Shared defines: state encodings (ysyx_22040931_ARB_IDLE/REQ/WAIT/RESP, 2 bits), owner encodings (OWNER_IF = 0, OWNER_MEM = 1), and the existing DATA/MEM bus width macros.
- Sub-module arb_grant: combinational grant logic plus the starvation counter.
- The FSM and payload registers stay in the top module.

Test Plan:
1. IF-only read:
   - Stimulus: if_addr = 0x80000004; bus accepts immediately; rsp one cycle later with data 0x11112222_33334444.
   - Response: if_rsp_data = 0x11112222, exactly 3 cycles after the handshake.
2. Simultaneous IF and MEM load:
   - Response: MEM is granted first; IF is granted in the cycle after MEM RESP.
   - Response: if_req_ready = 0 throughout the MEM transaction.
3. Starvation:
   - Stimulus: MEM valid continuously, IF valid continuously, STARVE_LIMIT = 4.
   - Response: grant sequence M, M, M, M, I, M…
4. Store:
   - Stimulus: addr 0x80001000, wdata 0xDEADBEEF, wmask 8'h0F; bus_req_ready delayed 3 cycles.
   - Response: bus_* stay stable for all 3 cycles; mem_rsp_valid is pulsed once.
5. Reset mid-operation:
   - Stimulus: assert reset during WAIT; after release, drive bus_rsp_valid.
   - Response: no rsp_valid pulse; all outputs 0; FSM in IDLE.
6. With ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 10:
   - Stimulus: no bus response.
   - Response: at WAIT cycle 10, arb_timeout = 1 together with mem_rsp_valid = 1 and data 0.
